dmem_bus_bridge: RTL and testbench

- Memory-side responder for the CPU data port. It accepts the M-stage request: address, write data, 4-bit byte write enables, and an enable. It returns the read data word.
- It converts each request into one transaction on an SRAM-like handshake bus (req/addr_ok/data_ok) with variable latency.
- It drives a stall to the hazard unit until the transaction completes.
- It sits between the datapath M stage and the AXI/SRAM wrapper. Read-data lane selection stays in the W-stage load logic; the bridge always returns a full word.

---
 rtl/dmem_bus_bridge_pkg.sv | 24 ++
 rtl/dmem_bus_bridge_bus_size_enc.sv | 54 +++++
 rtl/dmem_bus_bridge.sv | 164 ++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_bridge_pkg.sv
// Shared state encodings, bus size codes and address helper for the data-memory bridge.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_bus_bridge_pkg;

    // Bridge transaction states (2-bit encoding).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } busState_t;

    // Bus transfer size codes.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // kseg0/kseg1 (addr[31:30] == 2'b10) fold onto the low 512 MB physical window.
    function automatic logic [31:0] ksegMap(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10) ? {3'b000, vaddr[28:0]} : vaddr;
    endfunction

endpackage

// File: rtl/dmem_bus_bridge_bus_size_enc.sv
// Maps CPU byte write enables onto bus direction, transfer size and byte offset.
// Latency: combinational.
// Backpressure: none.
//
// Ports: wen (byte enables, 0 = read) -> wr, size, offset, illegal.
// Unsupported enable patterns fall back to a word transfer and raise illegal.
module bus_size_enc
    import dmem_bus_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic       wr,
    output logic [1:0] size,
    output logic [1:0] offset,
    output logic       illegal
);

    always_comb begin
        wr      = |wen;
        size    = SIZE_WORD;
        offset  = 2'b00;
        illegal = 1'b0;
        case (wen)
            4'b0000, 4'b1111: begin
                size = SIZE_WORD;
            end
            4'b0011: begin
                size = SIZE_HALF;
            end
            4'b1100: begin
                size   = SIZE_HALF;
                offset = 2'b10;
            end
            4'b0001: begin
                size = SIZE_BYTE;
            end
            4'b0010: begin
                size   = SIZE_BYTE;
                offset = 2'b01;
            end
            4'b0100: begin
                size   = SIZE_BYTE;
                offset = 2'b10;
            end
            4'b1000: begin
                size   = SIZE_BYTE;
                offset = 2'b11;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns each M-stage data access into one req/addr_ok/data_ok bus transaction.
// Latency: >= 2 cycles from cpu_en to stall release; result is held in DONE while cpu_hold.
// Backpressure: bus_req held until bus_addr_ok; cpu_stall held until data_ok or watchdog abort.
//
// Ports: cpu_* (M-stage request, returned word, stall, hold), bus_* (SRAM-like handshake bus),
//        bus_err (one-cycle pulse when the watchdog aborts a stuck transaction).
// Optional build macro: DMEM_KSEG_MAP_EN maps kseg0/kseg1 addresses to physical on bus_addr.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_hold,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam logic             WDOG_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);

    busState_t        state;
    logic [CNT_W-1:0] wdogCnt;
    logic             reqWr;
    logic [1:0]       reqSize;
    logic [31:0]      reqAddr;
    logic [31:0]      reqWdata;
    logic [31:0]      rdataQ;
    logic             busErrQ;

    logic             encWr;
    logic [1:0]       encSize;
    logic [1:0]       encOffset;
    logic             encIllegal;
    logic [31:0]      formedAddr;
    logic [31:0]      mappedAddr;
    logic             wdogHit;
    logic             unusedAddrLo;

    bus_size_enc uSizeEnc (
        .wen     (cpu_wen),
        .wr      (encWr),
        .size    (encSize),
        .offset  (encOffset),
        .illegal (encIllegal)
    );

    // Byte offset is derived from the lane-aligned enables, so the CPU's own
    // low address bits carry no extra information.
    assign unusedAddrLo = ^cpu_addr[1:0];
    assign formedAddr   = {cpu_addr[31:2], encOffset};

`ifdef DMEM_KSEG_MAP_EN
    assign mappedAddr = ksegMap(formedAddr);
`else
    assign mappedAddr = formedAddr;
`endif

    // Watchdog fires on the cycle that would take the no-progress count to TIMEOUT_CYC.
    assign wdogHit = WDOG_EN && (wdogCnt == WDOG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wdogCnt  <= '0;
            reqWr    <= 1'b0;
            reqSize  <= SIZE_WORD;
            reqAddr  <= '0;
            reqWdata <= '0;
            rdataQ   <= '0;
            busErrQ  <= 1'b0;
        end else begin
            busErrQ <= 1'b0;
            case (state)
                IDLE: begin
                    wdogCnt <= '0;
                    if (cpu_en) begin
                        reqWr    <= encWr;
                        reqSize  <= encSize;
                        reqAddr  <= mappedAddr;
                        reqWdata <= cpu_wdata;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        wdogCnt <= '0;
                        if (bus_data_ok) begin
                            if (!reqWr) begin
                                rdataQ <= bus_rdata;
                            end
                            state <= DONE;
                        end else begin
                            state <= DATA;
                        end
                    end else if (wdogHit) begin
                        wdogCnt <= '0;
                        busErrQ <= 1'b1;
                        rdataQ  <= '0;
                        state   <= DONE;
                    end else begin
                        wdogCnt <= wdogCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        wdogCnt <= '0;
                        if (!reqWr) begin
                            rdataQ <= bus_rdata;
                        end
                        state <= DONE;
                    end else if (wdogHit) begin
                        wdogCnt <= '0;
                        busErrQ <= 1'b1;
                        rdataQ  <= '0;
                        state   <= DONE;
                    end else begin
                        wdogCnt <= wdogCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Parked result: leave only once the pipeline is free to advance,
                    // otherwise the same M-stage access would be issued twice.
                    wdogCnt <= '0;
                    if (!cpu_hold) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Store enable patterns other than byte/aligned-half/word are not expected from the LSU.
    assert property (@(posedge clk) disable iff (!rst)
                     (state == IDLE && cpu_en) |-> !encIllegal);

    assign cpu_stall = cpu_en & (state != DONE);
    assign cpu_rdata = rdataQ;
    assign bus_err   = busErrQ;
    assign bus_req   = (state == ADDR);
    assign bus_wr    = reqWr;
    assign bus_size  = reqSize;
    assign bus_addr  = reqAddr;
    assign bus_wdata = reqWdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
module tb_dmem_bus_bridge;

    localparam int TMO   = 8;
    localparam int NEVER = 99;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_err;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    dmem_bus_bridge #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int stallSeen = 0;
    int errSeen   = 0;
    int reqSeen   = 0;

    logic        checkOn = 1'b0;
    logic        expStall, expReq, expErr, expWr;
    logic [1:0]  expSize;
    logic [31:0] expAddr, expWdata, expRdata;
    logic        pinVld = 1'b0;
    logic [1:0]  pinSize;
    logic [31:0] pinAddr;

    logic [3:0]  wenTab [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: what a request must look like on the bus, from the byte-enable rules.
    function automatic void model(input logic [3:0] wen, input logic [31:0] addr,
                                  output logic wr, output logic [1:0] size,
                                  output logic [31:0] baddr);
        int ones = 0;
        int low  = 0;
        for (int i = 3; i >= 0; i--) begin
            if (wen[i]) begin
                ones++;
                low = i;
            end
        end
        wr    = (ones != 0);
        size  = (ones == 1) ? 2'd0 : (ones == 2) ? 2'd1 : 2'd2;
        baddr = {addr[31:2], (ones == 1 || ones == 2) ? 2'(low) : 2'b00};
`ifdef DMEM_KSEG_MAP_EN
        if (baddr[31:30] == 2'b10) baddr = {3'b000, baddr[28:0]};
`endif
    endfunction

    // Per-cycle comparison against the expectations the stimulus publishes.
    always @(negedge clk) begin
        if (checkOn) begin
            if (cpu_stall) stallSeen++;
            if (bus_err)   errSeen++;
            if (bus_req)   reqSeen++;
            check("cpu_stall", 32'(cpu_stall), 32'(expStall));
            check("bus_req",   32'(bus_req),   32'(expReq));
            check("bus_err",   32'(bus_err),   32'(expErr));
            check("cpu_rdata", cpu_rdata,      expRdata);
            if (expReq) begin
                check("bus_wr",    32'(bus_wr),   32'(expWr));
                check("bus_size",  32'(bus_size), 32'(expSize));
                check("bus_addr",  bus_addr,      expAddr);
                check("bus_wdata", bus_wdata,     expWdata);
                if (pinVld) begin
                    check("pin_bus_addr", bus_addr,      pinAddr);
                    check("pin_bus_size", 32'(bus_size), 32'(pinSize));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_en      = 1'b0;
            cpu_hold    = 1'($urandom_range(0, 1));
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom;
            expStall = 1'b0; expReq = 1'b0; expErr = 1'b0;
            @(posedge clk); #1;
        end
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    // a: extra ADDR cycles before addr_ok (NEVER = no addr_ok);
    // d: cycles from addr_ok to data_ok, 0 = same cycle (NEVER = no data_ok).
    task automatic runTxn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rv, input int a, input int d, input int hold,
                          input bit dropEn);
        int doneK, reqEnd, addrOkK, dataOkK;
        bit aborted;
        if (a == NEVER) begin
            aborted = 1'b1; reqEnd = TMO; doneK = TMO + 1; addrOkK = -1; dataOkK = -1;
        end else begin
            reqEnd  = a + 1;
            addrOkK = a + 1;
            if (d == NEVER) begin
                aborted = 1'b1; dataOkK = -1; doneK = a + 2 + TMO;
            end else begin
                aborted = 1'b0; dataOkK = a + 1 + d; doneK = a + 2 + d;
            end
        end
        model(wen, addr, expWr, expSize, expAddr);
        expWdata = wdata;
        for (int k = 0; k < doneK; k++) begin
            if (k == 0) begin
                cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
            end else begin
                cpu_wen   = wenTab[$urandom_range(0, 7)];
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            cpu_en      = !(dropEn && k >= 1);
            cpu_hold    = 1'($urandom_range(0, 1));
            bus_addr_ok = (k == addrOkK);
            bus_data_ok = (k == dataOkK);
            bus_rdata   = (k == dataOkK) ? rv : $urandom;
            expStall = cpu_en;
            expReq   = (k >= 1 && k <= reqEnd);
            expErr   = 1'b0;
            @(posedge clk); #1;
        end
        if (aborted)        expRdata = 32'h0;
        else if (wen == 0)  expRdata = rv;
        for (int j = 0; j <= hold; j++) begin
            cpu_en      = !dropEn;
            cpu_hold    = (j < hold);
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom;
            expStall = 1'b0; expReq = 1'b0;
            expErr   = aborted && (j == 0);
            @(posedge clk); #1;
        end
        cpu_en = 1'b0; cpu_hold = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        expStall = 1'b0; expReq = 1'b0; expErr = 1'b0;
    endtask

    initial begin
        int a, d;
        rst = 1'b1;
        cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_hold = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        expStall = 1'b0; expReq = 1'b0; expErr = 1'b0; expRdata = 32'h0;
        expWr = 1'b0; expSize = 2'd2; expAddr = 32'h0; expWdata = 32'h0;
        pinSize = 2'd0; pinAddr = 32'h0;
        #3 rst = 1'b0;
        #10;
        check("reset_stall",  32'(cpu_stall), 32'h0);
        check("reset_req",    32'(bus_req),   32'h0);
        check("reset_err",    32'(bus_err),   32'h0);
        check("reset_rdata",  cpu_rdata,      32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        checkOn = 1'b1;
        idle(2);

        // Read, addr_ok and data_ok together: stalled for the capture cycle plus one ADDR cycle.
        pinVld = 1'b1; pinSize = 2'd2;
`ifdef DMEM_KSEG_MAP_EN
        pinAddr = 32'h0000_1234;
`else
        pinAddr = 32'h8000_1234;
`endif
        stallSeen = 0;
        runTxn(4'b0000, 32'h8000_1234, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
        check("read_stall_cycles", 32'(stallSeen), 32'd2);
        check("read_rdata", cpu_rdata, 32'hDEADBEEF);
        idle(1);

        // Byte write with slow address and data phases.
        pinAddr = 32'h0000_0102; pinSize = 2'd0;
        stallSeen = 0;
        runTxn(4'b0100, 32'h0000_0100, 32'h00AB_0000, 32'h1111_1111, 3, 2, 0, 1'b0);
        check("wbyte_stall_cycles", 32'(stallSeen), 32'd7);
        check("wbyte_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        idle(1);

        pinAddr = 32'h0000_2002; pinSize = 2'd1;
        runTxn(4'b1100, 32'h0000_2000, 32'hBEEF_0000, 32'h0, 1, 1, 0, 1'b0);
        pinAddr = 32'h0000_3000; pinSize = 2'd2;
        runTxn(4'b1111, 32'h0000_3003, 32'h0102_0304, 32'h0, 0, 3, 0, 1'b0);

        // Hold in DONE for 4 cycles, then a back-to-back access.
        pinVld = 1'b0;
        reqSeen = 0;
        runTxn(4'b0000, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 1, 4, 1'b0);
        check("hold_req_cycles", 32'(reqSeen), 32'd1);
        reqSeen = 0;
        runTxn(4'b0001, 32'h0000_0041, 32'h0000_005A, 32'h0, 2, 0, 0, 1'b0);
        check("next_req_cycles", 32'(reqSeen), 32'd3);

        // Watchdog, no addr_ok ever: 8 request cycles, then err pulse and zeroed data.
        errSeen = 0; reqSeen = 0;
        runTxn(4'b0000, 32'h0000_0080, 32'h0, 32'h5555_AAAA, NEVER, 0, 2, 1'b0);
        check("wdog_req_cycles", 32'(reqSeen), 32'd8);
        check("wdog_err_pulses", 32'(errSeen), 32'd1);
        check("wdog_rdata", cpu_rdata, 32'h0);
        bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        idle(3);
        check("wdog_late_data_ignored", cpu_rdata, 32'h0);

        // Watchdog in the data phase.
        runTxn(4'b0000, 32'h0000_0400, 32'h0, 32'h0, 1, NEVER, 0, 1'b0);

        // Async reset while in DATA.
        runTxn(4'b0000, 32'h0000_0500, 32'h0, 32'h7777_0000, 0, 0, 0, 1'b0);
        model(4'b0000, 32'h0000_0600, expWr, expSize, expAddr);
        expWdata = 32'h0;
        cpu_wen = 4'b0000; cpu_addr = 32'h0000_0600; cpu_wdata = 32'h0; cpu_en = 1'b1;
        expStall = 1'b1; expReq = 1'b0;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1; expReq = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; expReq = 1'b0;
        @(negedge clk);
        #2;
        checkOn = 1'b0;
        rst = 1'b0; cpu_en = 1'b0;
        #1;
        check("areset_req",   32'(bus_req),   32'h0);
        check("areset_stall", 32'(cpu_stall), 32'h0);
        check("areset_err",   32'(bus_err),   32'h0);
        check("areset_rdata", cpu_rdata,      32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        expRdata = 32'h0; expStall = 1'b0; expReq = 1'b0; expErr = 1'b0;
        checkOn = 1'b1;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = $urandom_range(0, 4);
            d = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) a = NEVER;
            else if ($urandom_range(0, 15) == 0) d = NEVER;
            runTxn(wenTab[$urandom_range(0, 7)], $urandom, $urandom, $urandom, a, d,
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 2));
        end

        checkOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
